uart_reg_file: RTL and testbench
================================

// Module: uart_reg_file
// PURPOSE
// UART register bank directly behind the APB slave front-end: decodes the forwarded APB access, holds the CFG/CTRL/TX/RX/STT registers, and returns write_en/read_en/prdata/parity_error so the front-end can raise pready/pslverr.
// Bridges software to the UART TX/RX cores through a TX request/ack handshake and an RX valid strobe.
// PARAMETERS
// ADDR_W     12            width of forwarded paddr
// CFG_RST    32'h0000_0003 reset value of CFG (8 data bits, 1 stop, no parity)
// PORTS
// clk             in   1   system clock; all logic on rising edge
// reset_n         in   1   synchronous active-low reset
// psel_i          in   1   forwarded psel
// penable_i       in   1   forwarded penable
// pwrite_i        in   1   forwarded pwrite
// paddr_i         in   12  forwarded paddr (0 when front-end idle)
// pstrb_i         in   4   byte strobes
// pwdata_i        in   32  write data
// write_en_o      out  1   write accepted (front-end pready source)
// read_en_o       out  1   read data valid on prdata_o
// prdata_o        out  32  read data, registered
// parity_error_o  out  1   sticky RX parity error, to front-end pslverr
// tx_req_o        out  1   request TX core to send tx_data_o
// tx_data_o       out  8   TX_DATA[7:0]
// tx_ack_i        in   1   TX core accepted byte (1-cycle pulse)
// tx_busy_i       in   1   TX core shifting
// rx_valid_i      in   1   RX core byte ready (1-cycle pulse)
// rx_data_i       in   8   received byte
// rx_perr_i       in   1   parity error qualifier for rx_valid_i
// cfg_o           out  5   CFG[4:0] to cores: [1:0] data bits-5, [2] 2 stop, [3] parity en, [4] odd parity
// BEHAVIOUR
// Map: 0x00 TX_DATA RW [7:0]; 0x04 RX_DATA RO [7:0]; 0x08 CFG RW [4:0]; 0x0C CTRL RW [0] start; 0x10 STT RO. Unimplemented bits read 0.
// Reset (reset_n=0 at edge): all outputs 0 except cfg_o=CFG_RST[4:0]; FSM=IDLE; all registers 0 except CFG.
// FSM IDLE: psel_i&penable_i -> DECODE. DECODE (1 wait state): perform write / capture read into prdata_o -> RESP.
// RESP: write_en_o=pwrite_i, read_en_o=~pwrite_i, held while psel_i&penable_i; when penable_i drops -> IDLE, enables and prdata_o cleared same edge.
// Latency: access phase seen at edge N -> enable high after edge N+2 (one wait state minimum).
// Writes honour pstrb_i per byte; writes to RO/unmapped addresses are ignored, but write_en_o still asserts (front-end flags error).
// Reads of unmapped addresses return 0 with read_en_o=1.
// CTRL[0] write 1: sets tx_req_o next cycle if tx_req_o=0; tx_req_o and CTRL[0] clear on tx_ack_i. Write 1 while tx_req_o=1 ignored.
// TX_DATA write while tx_req_o=1 updates register; tx_data_o is the value latched at tx_ack_i (core samples then).
// rx_valid_i: RX_DATA<=rx_data_i, STT.rx_done<=1; if rx_done already 1, STT.overrun<=1; rx_perr_i=1 sets parity_error_o.
// RX_DATA read (RESP entry) clears rx_done; simultaneous rx_valid_i wins: rx_done stays 1, no overrun.
// STT: [0] tx_busy_i|tx_req_o, [1] rx_done, [2] parity_error, [3] overrun. STT read clears [2],[3] at RESP entry; same-cycle new event keeps them set.
// parity_error_o is STT[2] registered, so it is stable for the whole RESP phase.
// psel_i dropped mid DECODE/RESP -> IDLE next edge, no side effects beyond those already committed at DECODE.
// Reset asserted mid-transfer or mid-TX request: all state returns to reset values; pending tx_req_o is dropped.
// TESTING
// Write CFG=0x1B, pstrb=4'h1 -> read CFG returns 0x1B; pstrb=4'h0 write of 0x00 leaves 0x1B; write_en_o pulses after 1 wait state.
// Write TX_DATA=0xA5, CTRL=1 -> tx_req_o=1, tx_data_o=0xA5; tx_ack_i pulse -> tx_req_o=0, CTRL reads 0.
// rx_valid_i with rx_data_i=0x3C -> STT=0x2, RX_DATA reads 0x3C, STT then 0x0.
// Two rx_valid_i (0x11,0x22) without read -> RX_DATA=0x22, STT[3]=1; STT read clears [3].
// rx_valid_i with rx_perr_i=1 -> parity_error_o=1 until STT read; rx_valid_i in RX_DATA-read cycle leaves rx_done=1.
// reset_n low during RESP of CFG write -> enables 0, CFG=CFG_RST, FSM IDLE next edge.

Source files
------------

// File: rtl/uart_reg_file.sv
// UART register bank behind the APB front-end: CFG/CTRL/TX/RX/STT registers,
// a one-wait-state access FSM, TX request/ack handshake and RX capture with sticky status.
module uart_reg_file #(
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] CFG_RST = 32'h0000_0003
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [3:0]        pstrb_i,
  input  logic [31:0]       pwdata_i,
  output logic              write_en_o,
  output logic              read_en_o,
  output logic [31:0]       prdata_o,
  output logic              parity_error_o,
  output logic              tx_req_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ack_i,
  input  logic              tx_busy_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_perr_i,
  output logic [4:0]        cfg_o
);

  localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(12'h000);
  localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(12'h004);
  localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(12'h008);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(12'h00C);
  localparam logic [ADDR_W-1:0] A_STT  = ADDR_W'(12'h010);

  typedef enum logic [1:0] {IDLE, DECODE, RESP} state_t;

  state_t      state;
  logic [7:0]  tx_data;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        overrun;
  logic        access;
  logic        wr_hit;
  logic        rd_hit;
  logic        wr_tx;
  logic        wr_cfg;
  logic        wr_ctrl;
  logic        rd_rx;
  logic        rd_stt;
  logic [3:0]  stt;
  logic [31:0] rdata;
  logic        unused_bits;

  // Only byte lane 0 carries implemented bits in every register.
  assign unused_bits = ^{pwdata_i[31:8], pstrb_i[3:1]};

  assign access  = psel_i & penable_i;
  assign wr_hit  = (state == DECODE) & access & pwrite_i & pstrb_i[0];
  assign rd_hit  = (state == DECODE) & access & ~pwrite_i;
  assign wr_tx   = wr_hit & (paddr_i == A_TX);
  assign wr_cfg  = wr_hit & (paddr_i == A_CFG);
  assign wr_ctrl = wr_hit & (paddr_i == A_CTRL) & pwdata_i[0];
  assign rd_rx   = rd_hit & (paddr_i == A_RX);
  assign rd_stt  = rd_hit & (paddr_i == A_STT);
  assign stt     = {overrun, parity_error_o, rx_done, tx_busy_i | tx_req_o};

  always_comb begin
    rdata = '0;
    case (paddr_i)
      A_TX:    rdata = {24'b0, tx_data};
      A_RX:    rdata = {24'b0, rx_data};
      A_CFG:   rdata = {27'b0, cfg_o};
      A_CTRL:  rdata = {31'b0, tx_req_o};
      A_STT:   rdata = {28'b0, stt};
      default: rdata = '0;
    endcase
  end

  // Access FSM: DECODE commits side effects, RESP holds the enables until penable drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      write_en_o <= 1'b0;
      read_en_o  <= 1'b0;
      prdata_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) state <= DECODE;
        end
        DECODE: begin
          if (access) begin
            prdata_o <= pwrite_i ? 32'b0 : rdata;
            state    <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP: begin
          if (access) begin
            write_en_o <= pwrite_i;
            read_en_o  <= ~pwrite_i;
          end else begin
            state      <= IDLE;
            write_en_o <= 1'b0;
            read_en_o  <= 1'b0;
            prdata_o   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_data        <= '0;
      tx_data_o      <= '0;
      tx_req_o       <= 1'b0;
      cfg_o          <= CFG_RST[4:0];
      rx_data        <= '0;
      rx_done        <= 1'b0;
      overrun        <= 1'b0;
      parity_error_o <= 1'b0;
    end else begin
      if (wr_tx)  tx_data <= pwdata_i[7:0];
      if (wr_cfg) cfg_o   <= pwdata_i[4:0];

      // The core samples the byte at ack; outside a request the output tracks the register.
      if (tx_ack_i) begin
        tx_req_o  <= 1'b0;
        tx_data_o <= wr_tx ? pwdata_i[7:0] : tx_data;
      end else begin
        if (wr_ctrl && !tx_req_o) tx_req_o <= 1'b1;
        if (wr_tx && !tx_req_o)   tx_data_o <= pwdata_i[7:0];
      end

      if (rx_valid_i) rx_data <= rx_data_i;

      if (rx_valid_i)   rx_done <= 1'b1;
      else if (rd_rx)   rx_done <= 1'b0;

      if (rx_valid_i && rx_done && !rd_rx) overrun <= 1'b1;
      else if (rd_stt)                     overrun <= 1'b0;

      if (rx_valid_i && rx_perr_i) parity_error_o <= 1'b1;
      else if (rd_stt)             parity_error_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_reg_file.sv
// Directed bench for uart_reg_file: register access, TX handshake, RX status and reset.
module tb_uart_reg_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic        write_en, read_en;
  logic [31:0] prdata;
  logic        parity_error;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_ack, tx_busy;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_perr;
  logic [4:0]  cfg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_reg_file #(.ADDR_W(12), .CFG_RST(32'h0000_0003)) dut (
    .clk(clk), .reset_n(reset_n),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pstrb_i(pstrb), .pwdata_i(pwdata),
    .write_en_o(write_en), .read_en_o(read_en), .prdata_o(prdata),
    .parity_error_o(parity_error),
    .tx_req_o(tx_req), .tx_data_o(tx_data), .tx_ack_i(tx_ack), .tx_busy_i(tx_busy),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_perr_i(rx_perr),
    .cfg_o(cfg)
  );

  // lat counts rising edges from the first edge that sees psel&penable to the enable.
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic inj, input logic [7:0] inj_data,
                      output logic [31:0] rdata, output int lat);
    @(negedge clk);
    psel = 1'b1; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    lat = 0;
    rdata = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (inj && i == 1) begin rx_valid = 1'b1; rx_data = inj_data; end
      if (inj && i == 2) rx_valid = 1'b0;
      if ((wr && write_en) || (!wr && read_en)) begin
        lat = i;
        rdata = prdata;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL xfer_timeout addr=%h wr=%0b: no enable within 10 cycles, required 3", addr, wr);
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output int lat);
    logic [31:0] dummy;
    xfer(1'b1, addr, data, strb, 1'b0, 8'h00, dummy, lat);
  endtask

  task automatic rd_reg(input logic [11:0] addr, output logic [31:0] rdata, output int lat);
    xfer(1'b0, addr, 32'h0, 4'h0, 1'b0, 8'h00, rdata, lat);
  endtask

  task automatic rx_pulse(input logic [7:0] d, input logic perr);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d; rx_perr = perr;
    @(negedge clk);
    rx_valid = 1'b0; rx_perr = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pstrb = '0; pwdata = '0;
    tx_ack = 0; tx_busy = 0; rx_valid = 0; rx_data = '0; rx_perr = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en got=%b exp=0", write_en); end
    checks++; if (read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en got=%b exp=0", read_en); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
    checks++; if (cfg !== 5'h03) begin errors++; $display("FAIL reset_cfg got=%h exp=03", cfg); end
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req got=%b exp=0", tx_req); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_parity got=%b exp=0", parity_error); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_cfg();
    logic [31:0] r;
    int lat;
    wr_reg(12'h008, 32'h0000_001B, 4'h1, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL cfg_wr_latency got=%0d exp=3", lat); end
    checks++; if (cfg !== 5'h1B) begin errors++; $display("FAIL cfg_out got=%h exp=1b", cfg); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL prdata_idle got=%h exp=0", prdata); end
    rd_reg(12'h008, r, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL cfg_rd_latency got=%0d exp=3", lat); end
    checks++; if (r !== 32'h1B) begin errors++; $display("FAIL cfg_read got=%h exp=1b", r); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL prdata_cleared got=%h exp=0", prdata); end
    wr_reg(12'h008, 32'h0000_0000, 4'h0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL cfg_nostrb_latency got=%0d exp=3", lat); end
    rd_reg(12'h008, r, lat);
    checks++; if (r !== 32'h1B) begin errors++; $display("FAIL cfg_nostrb_read got=%h exp=1b", r); end
  endtask

  task automatic test_tx();
    logic [31:0] r;
    int lat;
    wr_reg(12'h000, 32'h0000_00A5, 4'hF, lat);
    wr_reg(12'h00C, 32'h0000_0001, 4'hF, lat);
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL tx_req_set got=%b exp=1", tx_req); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL tx_data_out got=%h exp=a5", tx_data); end
    rd_reg(12'h010, r, lat);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL tx_stt_busy got=%h exp=1", r); end
    wr_reg(12'h000, 32'h0000_005A, 4'hF, lat);
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL tx_data_hold got=%h exp=a5", tx_data); end
    rd_reg(12'h00C, r, lat);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL ctrl_pending got=%h exp=1", r); end
    ack_pulse();
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL tx_req_clear got=%b exp=0", tx_req); end
    checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL tx_data_at_ack got=%h exp=5a", tx_data); end
    rd_reg(12'h00C, r, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL ctrl_after_ack got=%h exp=0", r); end
    tx_busy = 1'b1;
    rd_reg(12'h010, r, lat);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL stt_tx_busy got=%h exp=1", r); end
    tx_busy = 1'b0;
    rd_reg(12'h010, r, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL stt_idle got=%h exp=0", r); end
  endtask

  task automatic test_rx();
    logic [31:0] r;
    int lat;
    rx_pulse(8'h3C, 1'b0);
    rd_reg(12'h010, r, lat);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL rx_stt_done got=%h exp=2", r); end
    rd_reg(12'h004, r, lat);
    checks++; if (r !== 32'h3C) begin errors++; $display("FAIL rx_data got=%h exp=3c", r); end
    rd_reg(12'h010, r, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rx_stt_cleared got=%h exp=0", r); end
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    int lat;
    rx_pulse(8'h11, 1'b0);
    rx_pulse(8'h22, 1'b0);
    rd_reg(12'h004, r, lat);
    checks++; if (r !== 32'h22) begin errors++; $display("FAIL ovr_rx_data got=%h exp=22", r); end
    rd_reg(12'h010, r, lat);
    checks++; if (r !== 32'h8) begin errors++; $display("FAIL ovr_stt got=%h exp=8", r); end
    rd_reg(12'h010, r, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL ovr_stt_cleared got=%h exp=0", r); end
  endtask

  task automatic test_parity_collision();
    logic [31:0] r;
    int lat;
    rx_pulse(8'h55, 1'b1);
    checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL perr_set got=%b exp=1", parity_error); end
    rd_reg(12'h010, r, lat);
    checks++; if (r !== 32'h6) begin errors++; $display("FAIL perr_stt got=%h exp=6", r); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL perr_cleared got=%b exp=0", parity_error); end
    xfer(1'b0, 12'h004, 32'h0, 4'h0, 1'b1, 8'h66, r, lat);
    checks++; if (r !== 32'h55) begin errors++; $display("FAIL collide_rx_data got=%h exp=55", r); end
    rd_reg(12'h010, r, lat);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL collide_stt got=%h exp=2", r); end
    rd_reg(12'h004, r, lat);
    checks++; if (r !== 32'h66) begin errors++; $display("FAIL collide_new_data got=%h exp=66", r); end
    rd_reg(12'h010, r, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL collide_stt_final got=%h exp=0", r); end
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    int lat;
    rd_reg(12'h014, r, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL unmapped_rd_latency got=%0d exp=3", lat); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_rd got=%h exp=0", r); end
    wr_reg(12'h004, 32'h0000_00FF, 4'hF, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL ro_wr_latency got=%0d exp=3", lat); end
    rd_reg(12'h004, r, lat);
    checks++; if (r !== 32'h66) begin errors++; $display("FAIL ro_wr_ignored got=%h exp=66", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int lat;
    logic seen;
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h1F; pstrb = 4'h1;
    @(negedge clk);
    penable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (write_en) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_mid_no_write_en got=%b exp=1", seen); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL rst_mid_write_en got=%b exp=0", write_en); end
    checks++; if (cfg !== 5'h03) begin errors++; $display("FAIL rst_mid_cfg got=%h exp=03", cfg); end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    @(negedge clk);
    reset_n = 1'b1;
    rd_reg(12'h008, r, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rst_mid_idle_latency got=%0d exp=3", lat); end
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL rst_mid_cfg_read got=%h exp=3", r); end
    wr_reg(12'h00C, 32'h1, 4'h1, lat);
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL rst_tx_req_set got=%b exp=1", tx_req); end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL rst_tx_req_drop got=%b exp=0", tx_req); end
  endtask

  initial begin
    test_reset();
    test_cfg();
    test_tx();
    test_rx();
    test_overrun();
    test_parity_collision();
    test_unmapped();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
